// File: rtl/jtframe_pkg.sv
// Shared clocking-block definitions.
// Holds the reset-sequencer state encoding, so debug/OSD logic can decode the
// 3-bit st output, and the default timing constants.
// No ports: package only.
package jtframe_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_PWRUP     = 3'd2,
        ST_SDINIT    = 3'd3,
        ST_VIDEO     = 3'd4,
        ST_RUN       = 3'd5,
        ST_SOFT      = 3'd6
    } rstseq_st_t;

    localparam int RSTSEQ_LOCK_CYCLES  = 1024;
    localparam int RSTSEQ_SDRAM_WAIT   = 9600;  // 100 us at 96 MHz
    localparam int RSTSEQ_STAGE_GAP    = 16;
    localparam int RSTSEQ_INIT_TIMEOUT = 65536;

    function automatic int rstseq_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/jtframe_sync.sv
// Generic 2-flop synchroniser for a single-bit level crossing into clk.
// Ports:
//   clk   - destination clock
//   rst_n - synchronous active-low reset, clears both flops
//   din   - asynchronous input level
//   dout  - din re-timed to clk, 2 edges of latency
module jtframe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            // stage 0: may go metastable; stage 1: resolved level
            meta_p0 <= din;
            sync_p1 <= meta_p0;
        end
    end

    assign dout = sync_p1;

endmodule

// File: rtl/jtframe_rstseq.sv
// Reset sequencer for the clocking block.
// Qualifies PLL lock, then releases the SDRAM, video and game reset domains in
// that order. Losing lock re-arms the whole sequence; soft_rst re-runs only the
// game domain.
// Ports:
//   clk             - SDRAM-rate PLL clock
//   rst_n           - synchronous active-low reset
//   pll_locked      - PLL lock, asynchronous (synchronised here)
//   soft_rst        - game soft-reset request (level)
//   sdram_init_done - SDRAM controller finished its mode-register sequence
//   rst_sdram/rst_video/rst_game - active-high domain resets (registered)
//   ready           - high only in RUN
//   init_err        - sticky SDRAM init timeout flag
//   st              - current state for debug
module jtframe_rstseq
    import jtframe_pkg::*;
#(
    parameter int LOCK_CYCLES  = RSTSEQ_LOCK_CYCLES,
    parameter int SDRAM_WAIT   = RSTSEQ_SDRAM_WAIT,
    parameter int STAGE_GAP    = RSTSEQ_STAGE_GAP,
    parameter int INIT_TIMEOUT = RSTSEQ_INIT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_rst,
    input  logic       sdram_init_done,
    output logic       rst_sdram,
    output logic       rst_video,
    output logic       rst_game,
    output logic       ready,
    output logic       init_err,
    output logic [2:0] st
);

    localparam int CNT_MAX = rstseq_max4(LOCK_CYCLES, SDRAM_WAIT, STAGE_GAP, INIT_TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 2);

    typedef logic [CW-1:0] cnt_t;

    // Terminal counts: the counter starts at 0 on entry, so N cycles end at N-1.
    localparam cnt_t LOCK_LAST = cnt_t'(LOCK_CYCLES - 1);
    localparam cnt_t SDW_LAST  = cnt_t'(SDRAM_WAIT - 1);
    localparam cnt_t GAP_LAST  = cnt_t'(STAGE_GAP - 1);
    localparam cnt_t TO_LAST   = cnt_t'(INIT_TIMEOUT - 1);
    localparam cnt_t CNT_SAT   = '1;

    rstseq_st_t state;
    rstseq_st_t nxt;
    cnt_t       cnt;
    logic       locked_s;
    logic       init_done_p0;
    logic       cnt_run;
    logic       timeout;

    jtframe_sync u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pll_locked),
        .dout  (locked_s)
    );

    always_comb begin
        nxt     = state;
        cnt_run = 1'b0;
        timeout = 1'b0;
        case (state)
            ST_WAIT_LOCK: begin
                if (locked_s) nxt = ST_STABLE;
            end
            ST_STABLE: begin
                cnt_run = 1'b1;
                if (cnt == LOCK_LAST) nxt = ST_PWRUP;
            end
            ST_PWRUP: begin
                cnt_run = 1'b1;
                if (cnt == SDW_LAST) nxt = ST_SDINIT;
            end
            ST_SDINIT: begin
                cnt_run = 1'b1;
                // timeout wins over a done that arrives in the same cycle
                if (cnt == TO_LAST) begin
                    nxt     = ST_PWRUP;
                    timeout = 1'b1;
                end else if (init_done_p0) begin
                    nxt = ST_VIDEO;
                end
            end
            ST_VIDEO: begin
                cnt_run = 1'b1;
                if (cnt == GAP_LAST) nxt = ST_RUN;
            end
            ST_RUN: begin
                if (soft_rst) nxt = ST_SOFT;
            end
            ST_SOFT: begin
                // the hold count only advances once the request is released
                if (!soft_rst) begin
                    cnt_run = 1'b1;
                    if (cnt == GAP_LAST) nxt = ST_RUN;
                end
            end
            default: nxt = ST_WAIT_LOCK;
        endcase
        // lock loss overrides everything, including a pending timeout
        if (!locked_s && state != ST_WAIT_LOCK) begin
            nxt     = ST_WAIT_LOCK;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_WAIT_LOCK;
            cnt          <= '0;
            init_done_p0 <= 1'b0;
            init_err     <= 1'b0;
            rst_sdram    <= 1'b1;
            rst_video    <= 1'b1;
            rst_game     <= 1'b1;
            ready        <= 1'b0;
        end else begin
            state        <= nxt;
            init_done_p0 <= sdram_init_done;
            if (nxt != state)
                cnt <= '0;
            else if (cnt_run && cnt != CNT_SAT)
                cnt <= cnt + cnt_t'(1);
            if (timeout) init_err <= 1'b1;
            // outputs decoded from the next state so they change with it
            rst_sdram <= (nxt == ST_WAIT_LOCK) || (nxt == ST_STABLE) || (nxt == ST_PWRUP);
            rst_video <= !((nxt == ST_VIDEO) || (nxt == ST_RUN) || (nxt == ST_SOFT));
            rst_game  <= (nxt != ST_RUN);
            ready     <= (nxt == ST_RUN);
        end
    end

    assign st = state;

endmodule

// File: tb/tb_jtframe_rstseq.sv
module tb_jtframe_rstseq;
    import jtframe_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_rst;
    logic       sdram_init_done;
    logic       rst_sdram;
    logic       rst_video;
    logic       rst_game;
    logic       ready;
    logic       init_err;
    logic [2:0] st;

    jtframe_rstseq #(
        .LOCK_CYCLES  (4),
        .SDRAM_WAIT   (8),
        .STAGE_GAP    (2),
        .INIT_TIMEOUT (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .soft_rst        (soft_rst),
        .sdram_init_done (sdram_init_done),
        .rst_sdram       (rst_sdram),
        .rst_video       (rst_video),
        .rst_game        (rst_game),
        .ready           (ready),
        .init_err        (init_err),
        .st              (st)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      name;
        logic [7:0] exp;
    } sb_t;

    typedef struct {
        int         e;
        logic [2:0] s;
        logic       sd, vd, gm, rdy, err;
    } vec_t;

    sb_t  sb[$];
    sb_t  cur;
    vec_t nom[10];
    int   npass = 0;
    int   ntotal = 0;
    int   base;

    function automatic logic [7:0] pk(input rstseq_st_t s, input logic sd, input logic vd,
                                      input logic gm, input logic rdy, input logic err);
        return {3'(s), sd, vd, gm, rdy, err};
    endfunction

    task automatic push(input int at, input string name, input logic [7:0] exp);
        sb_t e;
        e.at = at; e.name = name; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // scoreboard: compare each queued expectation at the cycle it is due
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            ntotal++;
            if (cur.at < cyc) begin
                $display("FAIL %s: not sampled at cycle %0d (now %0d)", cur.name, cur.at, cyc);
            end else if ({st, rst_sdram, rst_video, rst_game, ready, init_err} !== cur.exp) begin
                $display("FAIL %s @%0d: got st=%0d sd=%b vd=%b gm=%b rdy=%b err=%b, want st=%0d sd=%b vd=%b gm=%b rdy=%b err=%b",
                         cur.name, cyc, st, rst_sdram, rst_video, rst_game, ready, init_err,
                         cur.exp[7:5], cur.exp[4], cur.exp[3], cur.exp[2], cur.exp[1], cur.exp[0]);
            end else begin
                npass++;
            end
        end
    end

    // Lock raised now (sampled at edge 0); init_done sampled at edge 20.
    task automatic run_nominal(input string tag);
        int b;
        pll_locked = 1'b1;
        b = cyc + 1;
        for (int i = 0; i < 10; i++)
            push(b + nom[i].e, $sformatf("%s_e%0d", tag, nom[i].e),
                 {nom[i].s, nom[i].sd, nom[i].vd, nom[i].gm, nom[i].rdy, nom[i].err});
        wait_until(b + 19);
        sdram_init_done = 1'b1;
        wait_until(b + 21);
        sdram_init_done = 1'b0;
        wait_until(b + 24);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        nom[0] = '{1,  3'(ST_WAIT_LOCK), 1, 1, 1, 0, 0};
        nom[1] = '{2,  3'(ST_STABLE),    1, 1, 1, 0, 0};
        nom[2] = '{5,  3'(ST_STABLE),    1, 1, 1, 0, 0};
        nom[3] = '{6,  3'(ST_PWRUP),     1, 1, 1, 0, 0};
        nom[4] = '{13, 3'(ST_PWRUP),     1, 1, 1, 0, 0};
        nom[5] = '{14, 3'(ST_SDINIT),    0, 1, 1, 0, 0};
        nom[6] = '{20, 3'(ST_SDINIT),    0, 1, 1, 0, 0};
        nom[7] = '{21, 3'(ST_VIDEO),     0, 0, 1, 0, 0};
        nom[8] = '{22, 3'(ST_VIDEO),     0, 0, 1, 0, 0};
        nom[9] = '{23, 3'(ST_RUN),       0, 0, 0, 1, 0};

        rst_n = 1'b0; pll_locked = 1'b0; soft_rst = 1'b0; sdram_init_done = 1'b0;

        // reset state, then idle without lock
        wait_until(3);
        push(4, "reset_state", pk(ST_WAIT_LOCK, 1, 1, 1, 0, 0));
        wait_until(4);
        rst_n = 1'b1;
        push(7, "idle_no_lock", pk(ST_WAIT_LOCK, 1, 1, 1, 0, 0));
        wait_until(8);

        run_nominal("nom");

        // soft reset: 5 cycles high in RUN
        soft_rst = 1'b1;
        base = cyc + 1;
        push(base,     "soft_enter",   pk(ST_SOFT, 0, 0, 1, 0, 0));
        push(base + 4, "soft_held",    pk(ST_SOFT, 0, 0, 1, 0, 0));
        push(base + 5, "soft_gap",     pk(ST_SOFT, 0, 0, 1, 0, 0));
        push(base + 6, "soft_release", pk(ST_RUN,  0, 0, 0, 1, 0));
        wait_until(base + 4);
        soft_rst = 1'b0;
        wait_until(base + 7);

        // lock loss in RUN, then relock and full sequence again
        pll_locked = 1'b0;
        base = cyc + 1;
        push(base + 1, "lockloss_e1", pk(ST_RUN,       0, 0, 0, 1, 0));
        push(base + 2, "lockloss_e2", pk(ST_WAIT_LOCK, 1, 1, 1, 0, 0));
        wait_until(base + 3);
        run_nominal("relock");

        // glitch in STABLE, then init timeout and a later successful init
        pll_locked = 1'b0;
        wait_until(cyc + 5);
        pll_locked = 1'b1;
        base = cyc + 1;
        push(base + 2,  "gl_stable",     pk(ST_STABLE,    1, 1, 1, 0, 0));
        push(base + 5,  "gl_stable_e5",  pk(ST_STABLE,    1, 1, 1, 0, 0));
        push(base + 6,  "gl_drop",       pk(ST_WAIT_LOCK, 1, 1, 1, 0, 0));
        push(base + 8,  "gl_wait",       pk(ST_WAIT_LOCK, 1, 1, 1, 0, 0));
        push(base + 9,  "gl_relock",     pk(ST_STABLE,    1, 1, 1, 0, 0));
        push(base + 12, "gl_cnt_restart",pk(ST_STABLE,    1, 1, 1, 0, 0));
        push(base + 13, "gl_pwrup",      pk(ST_PWRUP,     1, 1, 1, 0, 0));
        push(base + 21, "to_sdinit",     pk(ST_SDINIT,    0, 1, 1, 0, 0));
        push(base + 52, "to_last",       pk(ST_SDINIT,    0, 1, 1, 0, 0));
        push(base + 53, "to_err",        pk(ST_PWRUP,     1, 1, 1, 0, 1));
        push(base + 60, "to_rereset",    pk(ST_PWRUP,     1, 1, 1, 0, 1));
        push(base + 61, "to_sdinit2",    pk(ST_SDINIT,    0, 1, 1, 0, 1));
        push(base + 66, "to_video",      pk(ST_VIDEO,     0, 0, 1, 0, 1));
        push(base + 68, "to_err_sticky", pk(ST_RUN,       0, 0, 0, 1, 1));
        wait_until(base + 3);
        pll_locked = 1'b0;
        wait_until(base + 6);
        pll_locked = 1'b1;
        wait_until(base + 64);
        sdram_init_done = 1'b1;
        wait_until(base + 66);
        sdram_init_done = 1'b0;
        wait_until(base + 69);

        // rst_n pulse mid-SDINIT clears everything including init_err
        pll_locked = 1'b0;
        base = cyc + 1;
        push(base + 2, "err_after_loss", pk(ST_WAIT_LOCK, 1, 1, 1, 0, 1));
        wait_until(base + 4);
        pll_locked = 1'b1;
        base = cyc + 1;
        push(base + 2,  "rn_stable",     pk(ST_STABLE,    1, 1, 1, 0, 1));
        push(base + 15, "rn_sdinit",     pk(ST_SDINIT,    0, 1, 1, 0, 1));
        push(base + 16, "rn_reset",      pk(ST_WAIT_LOCK, 1, 1, 1, 0, 0));
        push(base + 18, "rn_sync_clear", pk(ST_WAIT_LOCK, 1, 1, 1, 0, 0));
        push(base + 19, "rn_restart",    pk(ST_STABLE,    1, 1, 1, 0, 0));
        wait_until(base + 15);
        rst_n = 1'b0;
        wait_until(base + 16);
        rst_n = 1'b1;
        wait_until(base + 20);

        wait_until(cyc + 2);
        if (sb.size() != 0) begin
            ntotal++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
